// File: rtl/issue_queue_multi.sv
// Out-of-order issue queue with CDB wakeup and oldest-first select.
// Age is a DEPTH x DEPTH matrix: age_q[j][i] set means entry j is older than entry i,
// so slot reuse never disturbs ordering.
module issue_queue_multi #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned TAG_W     = 6,
   parameter int unsigned OP_W      = 5,
   parameter int unsigned CDB_PORTS = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       insert_valid,
   output logic                       insert_ready,
   input  logic [OP_W-1:0]            opcode,
   input  logic [TAG_W-1:0]           src1_prf,
   input  logic [TAG_W-1:0]           src2_prf,
   input  logic                       src1_ready,
   input  logic                       src2_ready,
   input  logic [TAG_W-1:0]           dest_prf,
   input  logic [CDB_PORTS-1:0]       cdb_valid,
   input  logic [CDB_PORTS*TAG_W-1:0] cdb_tag,
   input  logic                       flush,
   output logic                       issue_valid,
   input  logic                       issue_ready,
   output logic [OP_W-1:0]            issue_opcode,
   output logic [TAG_W-1:0]           issue_src1_prf,
   output logic [TAG_W-1:0]           issue_src2_prf,
   output logic [TAG_W-1:0]           issue_dest_prf,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = IDX_W + 1;

   logic [DEPTH-1:0] valid_q, rdy1_q, rdy2_q;
   logic [OP_W-1:0]  opcode_q [DEPTH];
   logic [TAG_W-1:0] src1_q   [DEPTH];
   logic [TAG_W-1:0] src2_q   [DEPTH];
   logic [TAG_W-1:0] dest_q   [DEPTH];
   logic [DEPTH-1:0] age_q    [DEPTH];
   logic [CNT_W-1:0] count_q;

   logic [DEPTH-1:0] issuable, issue_sel, wake1, wake2;
   logic             ins_hit1, ins_hit2;
   logic [IDX_W-1:0] free_idx;
   logic             free_found;
   logic             do_insert, do_issue;

   // Tag match of every CDB port against stored sources and the incoming instruction.
   always_comb begin
      wake1    = '0;
      wake2    = '0;
      ins_hit1 = 1'b0;
      ins_hit2 = 1'b0;
      for (int k = 0; k < CDB_PORTS; k++) begin
         if (cdb_valid[k]) begin
            for (int i = 0; i < DEPTH; i++) begin
               if (valid_q[i] && src1_q[i] == cdb_tag[k*TAG_W +: TAG_W]) wake1[i] = 1'b1;
               if (valid_q[i] && src2_q[i] == cdb_tag[k*TAG_W +: TAG_W]) wake2[i] = 1'b1;
            end
            if (src1_prf == cdb_tag[k*TAG_W +: TAG_W]) ins_hit1 = 1'b1;
            if (src2_prf == cdb_tag[k*TAG_W +: TAG_W]) ins_hit2 = 1'b1;
         end
      end
   end

   // Oldest-ready select from registered state and one-hot field mux.
   always_comb begin
      issuable       = valid_q & rdy1_q & rdy2_q;
      issue_sel      = '0;
      issue_opcode   = '0;
      issue_src1_prf = '0;
      issue_src2_prf = '0;
      issue_dest_prf = '0;
      for (int i = 0; i < DEPTH; i++) begin
         logic older_ready;
         older_ready = 1'b0;
         for (int j = 0; j < DEPTH; j++) begin
            if (issuable[j] && age_q[j][i]) older_ready = 1'b1;
         end
         issue_sel[i] = issuable[i] && !older_ready;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (issue_sel[i]) begin
            issue_opcode   = issue_opcode | opcode_q[i];
            issue_src1_prf = issue_src1_prf | src1_q[i];
            issue_src2_prf = issue_src2_prf | src2_q[i];
            issue_dest_prf = issue_dest_prf | dest_q[i];
         end
      end
      issue_valid = |issuable;
   end

   // Lowest-index free slot receives the insert.
   always_comb begin
      free_idx   = '0;
      free_found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (!valid_q[i] && !free_found) begin
            free_idx   = IDX_W'(i);
            free_found = 1'b1;
         end
      end
   end

   // Handshakes; ready depends on registered occupancy only, flush cancels both.
   always_comb begin
      insert_ready = (count_q != CNT_W'(DEPTH));
      do_insert    = insert_valid && insert_ready && !flush;
      do_issue     = issue_valid && issue_ready && !flush;
      count        = count_q;
   end

   // Occupancy, valid bits and age matrix.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
      end else if (flush) begin
         valid_q <= '0;
         count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (do_issue && issue_sel[i]) valid_q[i] <= 1'b0;
            if (do_insert && free_idx == IDX_W'(i)) valid_q[i] <= 1'b1;
            for (int j = 0; j < DEPTH; j++) begin
               // New entry is younger than everything already present.
               if (do_insert && free_idx == IDX_W'(i)) age_q[i][j] <= 1'b0;
               else if (do_insert && free_idx == IDX_W'(j)) age_q[i][j] <= 1'b1;
            end
         end
         unique case ({do_insert, do_issue})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Entry payload and operand readiness (insert with bypass, or CDB wakeup).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy1_q <= '0;
         rdy2_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            opcode_q[i] <= '0;
            src1_q[i]   <= '0;
            src2_q[i]   <= '0;
            dest_q[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (do_insert && free_idx == IDX_W'(i)) begin
               opcode_q[i] <= opcode;
               src1_q[i]   <= src1_prf;
               src2_q[i]   <= src2_prf;
               dest_q[i]   <= dest_prf;
               rdy1_q[i]   <= src1_ready | ins_hit1;
               rdy2_q[i]   <= src2_ready | ins_hit2;
            end else begin
               if (wake1[i]) rdy1_q[i] <= 1'b1;
               if (wake2[i]) rdy2_q[i] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_issue_queue_multi.sv
// Bench for issue_queue_multi: directed scenarios then random traffic, all checked
// against an in-order list model (list position = age).
module tb_issue_queue_multi;

   localparam int DEPTH = 8;
   localparam int TAG_W = 6;
   localparam int OP_W  = 5;
   localparam int CDBP  = 2;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic                  insert_valid, insert_ready;
   logic [OP_W-1:0]       opcode;
   logic [TAG_W-1:0]      src1_prf, src2_prf, dest_prf;
   logic                  src1_ready, src2_ready;
   logic [CDBP-1:0]       cdb_valid;
   logic [CDBP*TAG_W-1:0] cdb_tag;
   logic                  flush;
   logic                  issue_valid, issue_ready;
   logic [OP_W-1:0]       issue_opcode;
   logic [TAG_W-1:0]      issue_src1_prf, issue_src2_prf, issue_dest_prf;
   logic [$clog2(DEPTH):0] count;

   issue_queue_multi #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W), .CDB_PORTS(CDBP)) dut (
      .clk(clk), .reset(reset),
      .insert_valid(insert_valid), .insert_ready(insert_ready),
      .opcode(opcode), .src1_prf(src1_prf), .src2_prf(src2_prf),
      .src1_ready(src1_ready), .src2_ready(src2_ready), .dest_prf(dest_prf),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_opcode(issue_opcode), .issue_src1_prf(issue_src1_prf),
      .issue_src2_prf(issue_src2_prf), .issue_dest_prf(issue_dest_prf),
      .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [OP_W-1:0]  op;
      logic [TAG_W-1:0] s1, s2, d;
      bit               r1, r2;
   } ent_t;

   ent_t q[$];
   int   n_checks = 0;
   int   n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
   endtask

   function automatic bit on_cdb(input logic [TAG_W-1:0] tag);
      for (int k = 0; k < CDBP; k++)
         if (cdb_valid[k] && cdb_tag[k*TAG_W +: TAG_W] == tag) return 1'b1;
      return 1'b0;
   endfunction

   task automatic idle();
      insert_valid = 0; opcode = '0; src1_prf = '0; src2_prf = '0; dest_prf = '0;
      src1_ready = 0; src2_ready = 0; cdb_valid = '0; cdb_tag = '0;
      flush = 0; issue_ready = 0;
   endtask

   task automatic ins(input int op, input int s1, input bit r1, input int s2, input bit r2,
                      input int d);
      insert_valid = 1; opcode = OP_W'(op);
      src1_prf = TAG_W'(s1); src1_ready = r1;
      src2_prf = TAG_W'(s2); src2_ready = r2; dest_prf = TAG_W'(d);
   endtask

   // Compare outputs with the model, then advance the model and the clock by one cycle.
   task automatic cycle();
      int          iss;
      bit          ins_ok;
      ent_t        e;
      logic [63:0] exp_f;
      #1;
      iss = -1;
      for (int i = 0; i < q.size(); i++)
         if (iss < 0 && q[i].r1 && q[i].r2) iss = i;
      exp_f = '0;
      if (iss >= 0) exp_f = {q[iss].op, q[iss].s1, q[iss].s2, q[iss].d};
      chk("count", count, q.size());
      chk("insert_ready", insert_ready, q.size() < DEPTH);
      chk("issue_valid", issue_valid, iss >= 0);
      chk("issue_fields", {issue_opcode, issue_src1_prf, issue_src2_prf, issue_dest_prf}, exp_f);
      if (flush) q.delete();
      else begin
         ins_ok = insert_valid && q.size() < DEPTH;
         for (int i = 0; i < q.size(); i++) begin
            if (on_cdb(q[i].s1)) q[i].r1 = 1;
            if (on_cdb(q[i].s2)) q[i].r2 = 1;
         end
         if (iss >= 0 && issue_ready) q.delete(iss);
         if (ins_ok) begin
            e.op = opcode; e.s1 = src1_prf; e.s2 = src2_prf; e.d = dest_prf;
            e.r1 = src1_ready || on_cdb(src1_prf);
            e.r2 = src2_ready || on_cdb(src2_prf);
            q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      #3;
      chk("reset_count", count, 0);
      chk("reset_insert_ready", insert_ready, 1);
      chk("reset_issue_valid", issue_valid, 0);
      chk("reset_fields", {issue_opcode, issue_src1_prf, issue_src2_prf, issue_dest_prf}, 0);
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;

      // Basic insert then issue.
      ins(3, 5, 1, 6, 1, 9); cycle();
      idle();
      chk("basic_valid", issue_valid, 1);
      chk("basic_fields", {issue_opcode, issue_src1_prf, issue_src2_prf, issue_dest_prf},
          {5'd3, 6'd5, 6'd6, 6'd9});
      chk("basic_count1", count, 1);
      issue_ready = 1; cycle(); idle();
      chk("basic_count0", count, 0);

      // Younger ready entry overtakes an older waiting one; CDB port 1 wakes the older.
      ins(10, 10, 0, 1, 1, 11); cycle();
      ins(11, 2, 1, 3, 1, 12); cycle();
      idle(); cycle();
      chk("ooo_first_B", issue_opcode, 11);
      issue_ready = 1; cycle();
      idle(); cdb_valid = 2'b10; cdb_tag = {6'd10, 6'd0}; cycle();
      idle();
      chk("ooo_wake_A", issue_opcode, 10);
      issue_ready = 1; cycle(); idle();

      // Same-cycle CDB bypass on insert.
      ins(7, 1, 1, 12, 0, 13); cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd12}; cycle();
      idle();
      chk("bypass_valid", issue_valid, 1);
      issue_ready = 1; cycle(); idle();

      // Fill to full; extra insert refused until an issue frees a slot.
      for (int i = 0; i < DEPTH; i++) begin
         ins(i, 1, 1, 2, 1, i); cycle();
      end
      chk("full_count", count, DEPTH);
      chk("full_not_ready", insert_ready, 0);
      ins(31, 1, 1, 2, 1, 31); cycle();
      chk("full_ignored", count, DEPTH);
      idle(); issue_ready = 1; cycle(); idle();
      chk("unfull_ready", insert_ready, 1);
      flush = 1; cycle(); idle();

      // Age order survives scattered slot reuse.
      ins(20, 30, 0, 0, 1, 1); cycle();
      ins(21, 31, 0, 0, 1, 2); cycle();
      ins(22, 32, 0, 0, 1, 3); cycle();
      ins(23, 1, 1, 0, 1, 4); cycle();
      idle(); issue_ready = 1; cycle();
      idle(); ins(1, 1, 1, 0, 1, 5); cycle();
      idle(); cdb_valid = 2'b01; cdb_tag = {6'd0, 6'd31}; cycle();
      idle(); issue_ready = 1; cycle();
      idle(); ins(2, 1, 1, 0, 1, 6); cycle();
      idle(); cdb_valid = 2'b10; cdb_tag = {6'd30, 6'd0}; cycle();
      idle(); issue_ready = 1; cycle();
      idle(); ins(3, 1, 1, 0, 1, 7); cycle();
      idle();
      for (int i = 1; i <= 3; i++) begin
         chk("reuse_order", issue_opcode, i);
         issue_ready = 1; cycle();
      end
      idle();

      // Flush with concurrent insert and issue.
      for (int i = 0; i < 5; i++) begin
         ins(i + 8, 1, 1, 2, 1, i); cycle();
      end
      ins(30, 1, 1, 2, 1, 30); issue_ready = 1; flush = 1; cycle(); idle();
      chk("flush_count", count, 0);
      chk("flush_issue_valid", issue_valid, 0);

      // Asynchronous reset mid-stream, then first insert after release.
      for (int i = 0; i < 3; i++) begin
         ins(i + 1, 1, 1, 2, 1, i); cycle();
      end
      idle();
      #2 reset = 0;
      #1;
      chk("async_count", count, 0);
      chk("async_insert_ready", insert_ready, 1);
      chk("async_issue_valid", issue_valid, 0);
      chk("async_fields", {issue_opcode, issue_src1_prf, issue_src2_prf, issue_dest_prf}, 0);
      q.delete();
      @(posedge clk); #1;
      reset = 1;
      ins(17, 4, 1, 4, 1, 17); cycle();
      idle(); cycle();
      chk("post_reset_oldest", issue_opcode, 17);

      // Random traffic; small tag range keeps wakeups frequent.
      for (int n = 0; n < 800; n++) begin
         insert_valid = ($urandom_range(0, 3) != 0);
         opcode       = OP_W'($urandom);
         src1_prf     = TAG_W'($urandom_range(0, 7));
         src2_prf     = TAG_W'($urandom_range(0, 7));
         dest_prf     = TAG_W'($urandom);
         src1_ready   = ($urandom_range(0, 2) == 0);
         src2_ready   = ($urandom_range(0, 2) == 0);
         cdb_valid    = CDBP'($urandom_range(0, 3));
         cdb_tag      = {TAG_W'($urandom_range(0, 7)), TAG_W'($urandom_range(0, 7))};
         issue_ready  = ($urandom_range(0, 2) != 0);
         flush        = ($urandom_range(0, 59) == 0);
         cycle();
      end
      idle(); cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
